// File: rtl/eports_pkg.sv
// Shared types and helpers for the e-port deserialiser/aligner.
// Holds the alignment FSM encoding, the default sync pattern and the word-width helper.
package eports_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } align_state_t;

   localparam logic [7:0] DEFAULT_SYNC_PATTERN = 8'hA5;

   function automatic int word_width(input int lanes, input int ratio);
      return lanes * ratio;
   endfunction

endpackage

// File: rtl/eports_gearbox.sv
// Beat gearbox: assembles LANES-wide beats into LANES*RATIO-bit words, lane-minor beat-major.
// A slip holds the beat counter for one clock so the frame boundary moves one beat later.
module eports_gearbox
   import eports_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int RATIO  = 8,
   parameter int SYNC_W = 8,
   parameter int BEAT_W = $clog2(RATIO)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [LANES-1:0]         eport_in,
   input  logic                     slip,
   output logic                     word_done,
   output logic [SYNC_W-1:0]        sync_field,
   output logic [LANES*RATIO-1:0]   eport_out,
   output logic                     word_valid,
   output logic [BEAT_W-1:0]        slip_count
);

   localparam int WORD_W = word_width(LANES, RATIO);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

   logic [BEAT_W-1:0] beat;
   logic [WORD_W-1:0] asm_q;
   logic [WORD_W-1:0] word_next;

   // The completed word includes the beat being presented on the completing clock.
   always_comb begin
      word_next = asm_q;
      word_next[beat*LANES +: LANES] = eport_in;
   end

   assign word_done  = (beat == LAST_BEAT);
   assign sync_field = word_next[SYNC_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat       <= '0;
         asm_q      <= '0;
         eport_out  <= '0;
         word_valid <= 1'b0;
         slip_count <= '0;
      end else begin
         asm_q      <= word_next;
         word_valid <= word_done;
         if (word_done) begin
            eport_out <= word_next;
         end
         if (slip) begin
            slip_count <= (slip_count == LAST_BEAT) ? '0 : slip_count + 1'b1;
         end else if (word_done) begin
            beat <= '0;
         end else begin
            beat <= beat + 1'b1;
         end
      end
   end

endmodule

// File: rtl/eports_deser_align.sv
// E-port deserialiser with sync-pattern word alignment, lock tracking and error counting.
// word_valid is a single-clock pulse with no backpressure; consumers qualify eport_out with locked.
module eports_deser_align
   import eports_pkg::*;
#(
   parameter int                LANES        = 4,
   parameter int                RATIO        = 8,
   parameter int                SYNC_W       = 8,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(DEFAULT_SYNC_PATTERN),
   parameter int                LOCK_CNT     = 4,
   parameter int                UNLOCK_CNT   = 2,
   parameter int                ERR_W        = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       align_en,
   input  logic                       err_clr,
   input  logic [LANES-1:0]           eport_in,
   output logic [LANES*RATIO-1:0]     eport_out,
   output logic                       word_valid,
   output logic                       locked,
   output logic [$clog2(RATIO)-1:0]   slip_count,
   output logic [ERR_W-1:0]           err_count,
   output align_state_t               state_dbg
);

   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

   align_state_t      state_q, state_d;
   logic [GOOD_W-1:0] good_q, good_d, good_inc;
   logic [BAD_W-1:0]  bad_q, bad_d, bad_inc;
   logic [ERR_W-1:0]  err_q, err_d;
   logic              slip_q, slip_d;
   logic              locked_q;
   logic              word_done;
   logic [SYNC_W-1:0] sync_field;
   logic              sync_ok;

   eports_gearbox #(
      .LANES  (LANES),
      .RATIO  (RATIO),
      .SYNC_W (SYNC_W)
   ) u_gearbox (
      .clk        (clk),
      .rst_n      (rst_n),
      .eport_in   (eport_in),
      .slip       (slip_q),
      .word_done  (word_done),
      .sync_field (sync_field),
      .eport_out  (eport_out),
      .word_valid (word_valid),
      .slip_count (slip_count)
   );

   assign sync_ok  = (sync_field == SYNC_PATTERN);
   assign good_inc = good_q + 1'b1;
   assign bad_inc  = bad_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= HUNT;
         good_q   <= '0;
         bad_q    <= '0;
         err_q    <= '0;
         slip_q   <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         good_q   <= good_d;
         bad_q    <= bad_d;
         err_q    <= err_d;
         slip_q   <= slip_d;
         locked_q <= (state_d == LOCKED);
      end
   end

   // The slip request is a one-clock pulse, so a slip issued before align_en drops still completes.
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      bad_d   = bad_q;
      err_d   = err_q;
      slip_d  = 1'b0;
      if (word_done && align_en) begin
         case (state_q)
            HUNT: begin
               if (sync_ok) begin
                  if (LOCK_CNT == 1) begin
                     state_d = LOCKED;
                     good_d  = '0;
                  end else begin
                     state_d = CHECK;
                     good_d  = GOOD_W'(1);
                  end
               end else begin
                  slip_d = 1'b1;
                  good_d = '0;
               end
            end
            CHECK: begin
               if (sync_ok) begin
                  if (good_inc == GOOD_W'(LOCK_CNT)) begin
                     state_d = LOCKED;
                     good_d  = '0;
                  end else begin
                     good_d = good_inc;
                  end
               end else begin
                  state_d = HUNT;
                  slip_d  = 1'b1;
                  good_d  = '0;
               end
            end
            LOCKED: begin
               if (sync_ok) begin
                  bad_d = '0;
               end else begin
                  if (err_q != {ERR_W{1'b1}}) begin
                     err_d = err_q + 1'b1;
                  end
                  // Losing lock does not slip; the next hunt starts from the current phase.
                  if (bad_inc == BAD_W'(UNLOCK_CNT)) begin
                     state_d = HUNT;
                     bad_d   = '0;
                  end else begin
                     bad_d = bad_inc;
                  end
               end
            end
            default: begin
               state_d = HUNT;
               good_d  = '0;
               bad_d   = '0;
            end
         endcase
      end
      if (err_clr) begin
         err_d = '0;
      end
   end

   assign locked    = locked_q;
   assign err_count = err_q;
   assign state_dbg = state_q;

endmodule

// File: doc/eports_deser_align.md
Name: eports_deser_align

Overview:
- Parametrised successor to the fixed 4-line, 8-beat trigger e-port capture.
- Deserialises LANES e-port lines, sampled at the fast e-port clock, into one WORD_W = LANES*RATIO bit word per RATIO clocks.
- Finds word-boundary alignment by beat-slipping against a sync pattern, and reports lock state and error counts.
- Sits between the e-port IO samplers and the 40 MHz-domain trigger data consumers.

Parameters:
- LANES, 4: e-port lines sampled per clock.
- RATIO, 8: beats per output word, >=2; word period in clocks.
- SYNC_W, 8: width of the sync field, located in eport_out[SYNC_W-1:0], <= WORD_W.
- SYNC_PATTERN, 8'hA5: expected sync field value.
- LOCK_CNT, 4: consecutive good words needed to declare lock.
- UNLOCK_CNT, 2: consecutive bad words while locked needed to drop lock.
- ERR_W, 16: error counter width.

Ports:
- clk, input, 1: e-port sampling clock (320 MHz).
- rst_n, input, 1: asynchronous, active-low reset.
- align_en, input, 1: 1 = run the alignment FSM; 0 = hold the current phase and state, no slips.
- err_clr, input, 1: synchronous clear of err_count.
- eport_in, input, LANES: e-port line samples, one beat per clock.
- eport_out, output, WORD_W: assembled word.
- word_valid, output, 1: one-clock pulse when eport_out updates.
- locked, output, 1: alignment achieved.
- slip_count, output, $clog2(RATIO): current phase offset in beats, modulo RATIO.
- err_count, output, ERR_W: saturating count of sync mismatches while locked.

Behaviour:
- Reset values (async on rst_n low): eport_out=0, word_valid=0, locked=0, slip_count=0, err_count=0, beat counter=0, FSM=HUNT, good/bad counters=0.
- Beat counter `beat` runs 0..RATIO-1 and wraps to 0.
- Each clock, eport_in[i] is captured to bit beat*LANES+i of the assembly register (lane-minor, beat-major).
- At the edge where beat==RATIO-1:
  - eport_out is loaded with the complete word, including the current eport_in.
  - word_valid=1 for exactly that following cycle.
  - Latency: eport_out/word_valid are valid one clock after the last beat is presented.
- Slip:
  - beat holds its value for one clock; that clock's sample overwrites the same slot.
  - The frame boundary therefore moves one beat later.
  - slip_count increments modulo RATIO.
  - At most one slip per word period.
- Sync compare: performed on each completed word (same edge as the eport_out load); good = word[SYNC_W-1:0]==SYNC_PATTERN.
- FSM (evaluated only at word completion when align_en=1):
  - HUNT: bad -> request a slip on the next clock, good counter=0, stay in HUNT. Good -> good counter=1, go to CHECK.
  - CHECK: good -> good counter+1; when it reaches LOCK_CNT, go to LOCKED and set locked=1. Bad -> slip, good counter=0, go to HUNT.
  - LOCKED: good -> bad counter=0. Bad -> bad counter+1 and err_count+1 (saturating at all-ones). When the bad counter reaches UNLOCK_CNT, go to HUNT, set locked=0, bad counter=0, no slip on this transition.
- With LOCK_CNT=1, the first good word in HUNT goes directly to LOCKED.
- align_en=0: word assembly and word_valid continue; FSM, counters and slip_count are frozen. A slip already requested still completes.
- err_clr: err_count=0. Simultaneous with an increment, clear wins.
- word_valid pulses in every state; consumers qualify data with locked.
- rst_n asserted mid-word: the partial word is discarded; after release, the first word_valid occurs RATIO clocks later.

Decomposition:
- Shared package `eports_pkg`:
  - FSM state enum (HUNT, CHECK, LOCKED).
  - Default sync pattern constant.
  - Function computing WORD_W.
- One natural sub-module: `eports_gearbox`. It holds the beat counter, slip input, assembly register, eport_out/word_valid and slip_count.
- The top-level block holds the FSM and counters.

Test Plan (LANES=4, RATIO=8, SYNC_PATTERN=8'hA5, LOCK_CNT=4, UNLOCK_CNT=2):
- Reset then a stream of words 32'h123456A5 with beat 0 on the first clock after reset release:
  - word_valid at clocks 8, 16, 24, 32 with eport_out=32'h123456A5.
  - locked rises with the 4th word; slip_count=0.
- Same stream offset by 3 beats:
  - Exactly 3 slips occur, one per word period; slip_count=3.
  - locked=1 after 4 subsequent good words; eport_out=32'h123456A5.
- While locked, inject one bad sync field (8'h00) -> locked stays 1, err_count=1. Then two consecutive bad words -> locked=0, err_count=3, FSM in HUNT.
- align_en=0 with a misaligned stream -> no slips; slip_count and locked unchanged; word_valid still pulses every 8 clocks.
- err_clr asserted on the same edge as a mismatch increment -> err_count=0. Also force err_count to its all-ones value (ERR_W=16: 16'hFFFF) with further bad words -> count stays 16'hFFFF.
- rst_n pulsed low mid-word while locked -> all outputs 0 immediately (asynchronously). First word_valid occurs 8 clocks after release.
